// File: rtl/loopmon_pkg.sv
// loopmon_pkg: shared state encoding, synchronizer depth and saturating increment
package loopmon_pkg;

    typedef enum logic [2:0] {IDLE, CAPTURE, WATCH, STABLE, OSC} state_e;

    localparam int SYNC_STAGES = 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/loopmon_sync.sv
// loopmon_sync: WIDTH-bit multi-flop synchronizer with async active-low reset
module loopmon_sync
    import loopmon_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] pipe;

    // shift each bit through SYNC_STAGES flops to resolve metastability
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[SYNC_STAGES-2:0], d};

    assign q = pipe[SYNC_STAGES-1];

endmodule

// File: rtl/loop_settle_monitor.sv
// loop_settle_monitor: watches loop nets after a start pulse and reports settle or oscillation.
// Optional LOOPMON_SYNC_EN inserts a 2-flop synchronizer on the nets (and on start, so the
// measurement window stays aligned with the synchronized samples).
module loop_settle_monitor
    import loopmon_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SETTLE_CYC = 8,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] nets_i,
    output logic             busy_o,
    output logic             stable_o,
    output logic             osc_o,
    output logic [CNT_W-1:0] toggle_cnt_o,
    output logic [CNT_W-1:0] settle_at_o,
    output logic [WIDTH-1:0] chg_mask_o
);

    localparam int          EW      = $clog2(TIMEOUT + 1);
    localparam int          QW      = $clog2(SETTLE_CYC + 1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [WIDTH-1:0] s, prev, d;
    logic             start_s, start_q, quiet_hit;
    logic [EW-1:0]    elapsed, elapsed_n;
    logic [QW-1:0]    quiet;
    state_e           state;

`ifdef LOOPMON_SYNC_EN
    loopmon_sync #(.WIDTH(WIDTH + 1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({start_i, nets_i}),
        .q    ({start_s, s})
    );
`else
    assign start_s = start_i;
    assign s       = nets_i;
`endif

    // register the start request so the capture sample is taken one cycle after it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) start_q <= 1'b0;
        else        start_q <= start_s;

    // per-sample change vector and exit conditions
    always_comb begin
        d         = s ^ prev;
        elapsed_n = elapsed + 1'b1;
        quiet_hit = (d == '0) && (32'(quiet) + 32'd1 == 32'(SETTLE_CYC));
    end

    // measurement FSM with registered verdicts, counters and change mask
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            prev         <= '0;
            elapsed      <= '0;
            quiet        <= '0;
            busy_o       <= 1'b0;
            stable_o     <= 1'b0;
            osc_o        <= 1'b0;
            toggle_cnt_o <= '0;
            settle_at_o  <= '0;
            chg_mask_o   <= '0;
        end else begin
            case (state)
                IDLE, STABLE, OSC:
                    if (start_q) begin
                        state    <= CAPTURE;
                        busy_o   <= 1'b1;
                        stable_o <= 1'b0;
                        osc_o    <= 1'b0;
                    end
                CAPTURE: begin
                    prev         <= s;
                    elapsed      <= '0;
                    quiet        <= '0;
                    toggle_cnt_o <= '0;
                    settle_at_o  <= '0;
                    chg_mask_o   <= '0;
                    state        <= WATCH;
                end
                WATCH: begin
                    prev    <= s;
                    elapsed <= elapsed_n;
                    if (d != '0) begin
                        quiet        <= '0;
                        toggle_cnt_o <= CNT_W'(sat_inc(32'(toggle_cnt_o), CNT_MAX));
                        chg_mask_o   <= chg_mask_o | d;
                        settle_at_o  <= (32'(elapsed_n) > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(elapsed_n);
                    end else begin
                        quiet <= quiet + 1'b1;
                    end
                    if (quiet_hit) begin
                        state    <= STABLE;
                        stable_o <= 1'b1;
                        busy_o   <= 1'b0;
                    end else if (32'(elapsed_n) == 32'(TIMEOUT)) begin
                        state  <= OSC;
                        osc_o  <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end

endmodule
